key_event_scheduler: RTL and testbench

//   Turns the synchronised key levels of the vending-machine front panel into single press events.

---
 rtl/key_event_scheduler.sv | 119 +++++++++++
 tb/tb_key_event_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_scheduler.sv
// Front-panel key scheduler: hold-time qualification, round-robin arbitration
// of accepted presses into an event FIFO drained over valid/ready.
module key_event_scheduler #(
    parameter int unsigned NKEYS       = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NKEYS-1:0]           keyin,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NKEYS)-1:0]   evt_key,
    output logic [NKEYS-1:0]           pending,
    output logic                       overflow
);

    localparam int unsigned KW = $clog2(NKEYS);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = AW + 1;

    logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NKEYS-1:0]         press;
    logic [NKEYS-1:0]         pending_q, pending_d;
    logic                     overflow_q, overflow_d;
    logic [KW-1:0]            rr_ptr_q;
    logic [KW-1:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]            count_q, count_d;
    logic                     pop, can_push, grant_vld;
    logic [KW-1:0]            grant_idx;
    logic [NKEYS-1:0]         grant_vec;
    int unsigned              idx;

    // Counters saturate at HOLD_CYCLES so a press fires once per high run.
    always_comb begin
        cnt_d = cnt_q;
        press = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (!keyin[i]) begin
                cnt_d[i] = '0;
            end else begin
                press[i] = (cnt_q[i] == CW'(HOLD_CYCLES - 1));
                if (cnt_q[i] != CW'(HOLD_CYCLES)) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    assign can_push  = (count_q < NW'(FIFO_DEPTH)) || pop;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NKEYS; k++) begin
            idx = (32'(rr_ptr_q) + k) % NKEYS;
            if (can_push && !grant_vld && pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = KW'(idx);
            end
        end
        if (grant_vld) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A press on a key granted this cycle refills its pending slot, no drop.
    always_comb begin
        pending_d  = (pending_q & ~grant_vec) | press;
        overflow_d = overflow_q | (|(press & pending_q & ~grant_vec));
        count_d    = count_q;
        unique case ({grant_vld, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            rr_ptr_q   <= KW'(NKEYS - 1);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (grant_vld) begin
                rr_ptr_q <= grant_idx;
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            mem[wr_ptr_q] <= grant_idx;
        end
    end

    assign evt_key  = evt_valid ? mem[rd_ptr_q] : '0;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with hand-computed expectations.
module tb_key_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] keyin;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [2:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int got_q[$];

    key_event_scheduler #(
        .NKEYS      (3),
        .HOLD_CYCLES(4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .keyin    (keyin),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted event, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) got_q.push_back(int'(evt_key));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic press_run(input int key, input int len);
        keyin[key] = 1'b1;
        tick(len);
        keyin[key] = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        tick(10);
        evt_ready = 1'b0;
    endtask

    task automatic burst_check(input string tag);
        keyin = 3'b111;
        tick(4);
        check({tag, "_pend_all"}, 32'(pending), 32'd7);
        tick(1);
        check({tag, "_pend_g0"}, 32'(pending), 32'd6);
        tick(1);
        check({tag, "_pend_g1"}, 32'(pending), 32'd4);
        tick(1);
        check({tag, "_pend_g2"}, 32'(pending), 32'd0);
        keyin = 3'b000;
        got_q.delete();
        drain();
        check({tag, "_n"}, 32'(got_q.size()), 32'd3);
        for (int i = 0; i < got_q.size() && i < 3; i++) check({tag, "_ord"}, got_q[i], i);
    endtask

    initial begin
        reset     = 1'b1;
        keyin     = '0;
        evt_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_key", 32'(evt_key), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);

        // 1: key1 held 6 cycles, event visible only after the 5th edge.
        evt_ready = 1'b1;
        got_q.delete();
        keyin[1] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick(1);
            check("t1_valid", 32'(evt_valid), 32'(j == 5));
            if (j == 4) check("t1_pending", 32'(pending), 32'd2);
            if (j == 5) check("t1_key", 32'(evt_key), 32'd1);
        end
        keyin[1] = 1'b0;
        tick(3);
        check("t1_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t1_evkey", got_q[0], 32'd1);

        // 2: runs of 3 are too short.
        got_q.delete();
        for (int r = 0; r < 3; r++) begin
            press_run(0, 3);
            check("t2_pending", 32'(pending), 0);
        end
        tick(2);
        check("t2_valid", 32'(evt_valid), 0);
        check("t2_events", 32'(got_q.size()), 0);

        // 3: simultaneous presses, twice, both ordered 0,1,2.
        evt_ready = 1'b0;
        do_reset();
        burst_check("t3a");
        burst_check("t3b");

        // 5: full FIFO plus pending[0], one pop cycle pushes key0.
        do_reset();
        for (int r = 0; r < 4; r++) press_run(1, 4);
        press_run(0, 4);
        check("t5_pend", 32'(pending), 32'd1);
        check("t5_valid", 32'(evt_valid), 1);
        got_q.delete();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t5_pend_clr", 32'(pending), 0);
        check("t5_pop_n", 32'(got_q.size()), 1);
        drain();
        check("t5_total", 32'(got_q.size()), 5);
        for (int i = 0; i < got_q.size() && i < 5; i++)
            check("t5_ord", got_q[i], (i < 4) ? 32'd1 : 32'd0);

        // 4: five presses on key2 with no consumer, then a sixth.
        do_reset();
        for (int r = 0; r < 5; r++) press_run(2, 4);
        check("t4_pend", 32'(pending), 32'd4);
        check("t4_key", 32'(evt_key), 32'd2);
        check("t4_ovf0", 32'(overflow), 0);
        press_run(2, 4);
        check("t4_ovf1", 32'(overflow), 1);
        check("t4_pend2", 32'(pending), 32'd4);
        got_q.delete();
        drain();
        check("t4_drain_n", 32'(got_q.size()), 5);
        for (int i = 0; i < got_q.size() && i < 5; i++) check("t4_ord", got_q[i], 32'd2);
        check("t4_ovf_sticky", 32'(overflow), 1);

        // 6: reset mid-stream with key0 held; overflow still set from above.
        press_run(1, 4);
        press_run(1, 4);
        keyin[0] = 1'b1;
        tick(2);
        check("t6_pre_valid", 32'(evt_valid), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_valid", 32'(evt_valid), 0);
        check("t6_pending", 32'(pending), 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_key", 32'(evt_key), 0);
        tick(3);
        check("t6_no_early", 32'(pending), 0);
        tick(1);
        check("t6_press", 32'(pending), 32'd1);
        tick(1);
        check("t6_evt_valid", 32'(evt_valid), 1);
        check("t6_evt_key", 32'(evt_key), 0);
        keyin = '0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
